// File: rtl/fetch_align_if.sv
// Bundle of signals between fetch_align, instruction memory, decode and the
// branch/return redirect source. fetch_align uses the slave view; the
// surrounding memory/decode/redirect logic uses the master view.
interface fetch_align_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] fetch_data;
  logic [23:0] instr;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        instr_v;
  logic        instr_ready;
  logic        redirect_v;
  logic [15:0] redirect_pc;

  modport slave (
    output fetch_req, fetch_addr, instr, instr_len, instr_pc, instr_v,
    input  fetch_data, instr_ready, redirect_v, redirect_pc
  );

  modport master (
    input  fetch_req, fetch_addr, instr, instr_len, instr_pc, instr_v,
    output fetch_data, instr_ready, redirect_v, redirect_pc
  );
endinterface

// File: rtl/fetch_align.sv
// fetch_align: fetches 16-bit byte pairs, queues up to 6 bytes and presents
// decode with a length-decoded 8080 instruction window.
// Optional macro FETCH_ALIGN_UNDOC_EN: undocumented opcode aliases CB, DD,
// ED and FD decode as 3-byte instructions; otherwise they are 1 byte.
module fetch_align #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic         clk,
  input logic         reset,
  fetch_align_if.slave bus
);

  localparam int unsigned QDEPTH = 6;

  logic [7:0]  mem_q [QDEPTH];
  logic [7:0]  mem_d [QDEPTH];
  logic [2:0]  head_q, head_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] pc_q, pc_d;
  logic        fetch_req_q, fetch_req_d;
  logic [15:0] fetch_addr_q, fetch_addr_d;
  logic [15:0] next_addr_q, next_addr_d;
  logic        resp_pend_q, resp_pend_d;
  logic        drop_hi_q, drop_hi_d;

  logic [2:0]  idx1, idx2;
  logic [7:0]  b0, b1, b2;
  logic [1:0]  hd_len;
  logic        win_v;

  logic        accept;
  logic [3:0]  in_bytes;
  logic [3:0]  count_after;
  logic [3:0]  budget;
  logic        issue;
  logic [2:0]  wr0, wr1;

  // Circular index arithmetic over the 6 queue slots (inputs never exceed 12).
  function automatic logic [2:0] wrap6(input logic [3:0] s);
    logic [3:0] r;
    r = s;
    if (r >= 4'd12)     r = r - 4'd12;
    else if (r >= 4'd6) r = r - 4'd6;
    return r[2:0];
  endfunction

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] l;
    l = 2'd1;
    if (((op & 8'hC7) == 8'h06) || ((op & 8'hC7) == 8'hC6) ||
        (op == 8'hDB) || (op == 8'hD3))
      l = 2'd2;
    if (((op & 8'hCF) == 8'h01) || (op == 8'h22) || (op == 8'h2A) ||
        (op == 8'h32) || (op == 8'h3A) || (op == 8'hC3) ||
        ((op & 8'hC7) == 8'hC2) || (op == 8'hCD) || ((op & 8'hC7) == 8'hC4))
      l = 2'd3;
`ifdef FETCH_ALIGN_UNDOC_EN
    if ((op == 8'hCB) || (op == 8'hDD) || (op == 8'hED) || (op == 8'hFD))
      l = 2'd3;
`endif
    return l;
  endfunction

  // Instruction window: head bytes and length, from queue registers only.
  always_comb begin
    idx1   = wrap6({1'b0, head_q} + 4'd1);
    idx2   = wrap6({1'b0, head_q} + 4'd2);
    b0     = mem_q[head_q];
    b1     = mem_q[idx1];
    b2     = mem_q[idx2];
    hd_len = op_len(b0);
    win_v  = (count_q >= {1'b0, hd_len});
  end

  assign bus.instr_v    = win_v;
  assign bus.instr_len  = win_v ? hd_len : 2'd0;
  assign bus.instr      = win_v ? {b0,
                                   (hd_len != 2'd1) ? b1 : 8'h00,
                                   (hd_len == 2'd3) ? b2 : 8'h00} : 24'h000000;
  assign bus.instr_pc   = pc_q;
  assign bus.fetch_req  = fetch_req_q;
  assign bus.fetch_addr = fetch_addr_q;

  // Queue update, request issue and redirect handling.
  always_comb begin
    mem_d        = mem_q;
    head_d       = head_q;
    count_d      = count_q;
    pc_d         = pc_q;
    fetch_req_d  = fetch_req_q;
    fetch_addr_d = fetch_addr_q;
    next_addr_d  = next_addr_q;
    resp_pend_d  = resp_pend_q;
    drop_hi_d    = drop_hi_q;

    accept      = win_v & bus.instr_ready;
    in_bytes    = resp_pend_q ? (drop_hi_q ? 4'd1 : 4'd2) : 4'd0;
    count_after = {1'b0, count_q} + in_bytes - (accept ? {2'b00, hd_len} : 4'd0);
    // A request issued now lands two cycles out; the one already on the bus
    // lands next cycle, so both are reserved before granting a new one.
    budget      = count_after + (fetch_req_q ? 4'd2 : 4'd0) + 4'd2;
    issue       = (budget <= 4'd6);
    wr0         = wrap6({1'b0, head_q} + {1'b0, count_q});
    wr1         = wrap6({1'b0, head_q} + {1'b0, count_q} + 4'd1);

    if (bus.redirect_v) begin
      head_d       = 3'd0;
      count_d      = 3'd0;
      pc_d         = bus.redirect_pc;
      resp_pend_d  = 1'b0;
      drop_hi_d    = bus.redirect_pc[0];
      fetch_req_d  = 1'b1;
      fetch_addr_d = {bus.redirect_pc[15:1], 1'b0};
      next_addr_d  = {bus.redirect_pc[15:1], 1'b0} + 16'd2;
    end else begin
      if (resp_pend_q) begin
        if (drop_hi_q) begin
          mem_d[wr0] = bus.fetch_data[7:0];
        end else begin
          mem_d[wr0] = bus.fetch_data[15:8];
          mem_d[wr1] = bus.fetch_data[7:0];
        end
        drop_hi_d = 1'b0;
      end
      if (accept) begin
        head_d = wrap6({1'b0, head_q} + {2'b00, hd_len});
        pc_d   = pc_q + {14'd0, hd_len};
      end
      count_d     = count_after[2:0];
      resp_pend_d = fetch_req_q;
      fetch_req_d = issue;
      if (issue) begin
        fetch_addr_d = next_addr_q;
        next_addr_d  = next_addr_q + 16'd2;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q        <= '{default: 8'h00};
      head_q       <= 3'd0;
      count_q      <= 3'd0;
      pc_q         <= RESET_PC;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= RESET_PC;
      next_addr_q  <= {RESET_PC[15:1], 1'b0};
      resp_pend_q  <= 1'b0;
      drop_hi_q    <= RESET_PC[0];
    end else begin
      mem_q        <= mem_d;
      head_q       <= head_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      next_addr_q  <= next_addr_d;
      resp_pend_q  <= resp_pend_d;
      drop_hi_q    <= drop_hi_d;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Testbench for fetch_align: memory image model, instruction-stream
// scoreboard and directed/random stimulus.
module tb_fetch_align;

  logic clk;
  logic reset;

  fetch_align_if bus();

  fetch_align #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef FETCH_ALIGN_UNDOC_EN
  localparam int CB_LEN = 3;
`else
  localparam int CB_LEN = 1;
`endif

  typedef struct {
    logic [23:0] instr;
    logic [1:0]  len;
    logic [15:0] pc;
  } exp_t;

  logic [7:0]  img [65536];
  exp_t        exp_q [$];
  logic [15:0] model_pc;
  logic [15:0] exp_fa;
  logic        mon_en;
  int          n_checks;
  int          n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Instruction length table for the 8080 opcode map.
  function automatic int ref_len(input logic [7:0] op);
    casez (op)
      8'b00???110, 8'b11???110, 8'hDB, 8'hD3: return 2;
      8'b00??0001, 8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3,
      8'b11???010, 8'hCD, 8'b11???100: return 3;
`ifdef FETCH_ALIGN_UNDOC_EN
      8'hCB, 8'hDD, 8'hED, 8'hFD: return 3;
`endif
      default: return 1;
    endcase
  endfunction

  function automatic void push_next();
    exp_t e;
    int l;
    logic [15:0] p;
    p = model_pc;
    l = ref_len(img[p]);
    e.pc    = p;
    e.len   = 2'(l);
    e.instr = {img[p], (l >= 2) ? img[p + 16'd1] : 8'h00, (l == 3) ? img[p + 16'd2] : 8'h00};
    exp_q.push_back(e);
    model_pc = p + 16'(l);
  endfunction

  function automatic void refill();
    while (exp_q.size() < 8) push_next();
  endfunction

  function automatic void model_restart(input logic [15:0] p);
    exp_q.delete();
    model_pc = p;
    exp_fa   = {p[15:1], 1'b0};
    refill();
  endfunction

  // Memory: a pair requested in one cycle is returned in the next; garbage otherwise.
  initial begin
    logic        rq;
    logic [15:0] ra;
    rq = 1'b0;
    ra = 16'h0000;
    bus.fetch_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (rq) bus.fetch_data = {img[ra], img[ra + 16'd1]};
      else    bus.fetch_data = 16'($urandom);
      rq = bus.fetch_req;
      ra = bus.fetch_addr;
    end
  end

  // Monitor: request address sequence and accepted instructions vs scoreboard.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (bus.fetch_req) begin
        chk("fetch_addr", 32'(bus.fetch_addr), 32'(exp_fa));
        exp_fa = exp_fa + 16'd2;
      end
      if (bus.instr_v && bus.instr_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr", 32'(bus.instr), 32'(e.instr));
        chk("instr_len", 32'(bus.instr_len), 32'(e.len));
        chk("instr_pc", 32'(bus.instr_pc), 32'(e.pc));
      end else if (!bus.instr_v) begin
        chk("idle_window", 32'({bus.instr_len, bus.instr}), 32'd0);
      end
      if (bus.redirect_v) model_restart(bus.redirect_pc);
      refill();
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v(input string name);
    int k;
    k = 0;
    while (bus.instr_v !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (bus.instr_v !== 1'b1) chk(name, 32'(bus.instr_v), 32'd1);
  endtask

  task automatic redirect_pulse(input logic [15:0] p);
    bus.redirect_v  = 1'b1;
    bus.redirect_pc = p;
    next_cycle();
    bus.redirect_v  = 1'b0;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 4) begin
        bus.redirect_v = 1'b1;
        if ($urandom_range(0, 3) == 0) bus.redirect_pc = 16'hFFF0 + 16'($urandom_range(0, 15));
        else                            bus.redirect_pc = 16'($urandom);
      end else begin
        bus.redirect_v = 1'b0;
      end
    end
    next_cycle();
    bus.redirect_v = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    model_pc = 16'h0000;
    exp_fa   = 16'h0000;
    reset    = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect_v  = 1'b0;
    bus.redirect_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) img[i] = 8'($urandom);

    // Cold start with a 2-byte opcode.
    img[0] = 8'h3E; img[1] = 8'h42; img[2] = 8'h00; img[3] = 8'h00;
    repeat (3) next_cycle();
    chk("reset_req", 32'(bus.fetch_req), 32'd0);
    chk("reset_addr", 32'(bus.fetch_addr), 32'h0000);
    chk("reset_pc", 32'(bus.instr_pc), 32'h0000);
    chk("reset_window", 32'({bus.instr_v, bus.instr_len, bus.instr}), 32'd0);
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    model_restart(16'h0000);
    mon_en = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("c0_req", 32'(bus.fetch_req), 32'd1);
    chk("c0_addr", 32'(bus.fetch_addr), 32'h0000);
    @(negedge clk);
    chk("c1_v", 32'(bus.instr_v), 32'd0);
    @(negedge clk);
    chk("c2_v", 32'(bus.instr_v), 32'd1);
    chk("c2_instr", 32'(bus.instr), 32'h3E4200);
    chk("c2_len", 32'(bus.instr_len), 32'd2);
    chk("c2_pc", 32'(bus.instr_pc), 32'h0000);
    @(negedge clk);
    chk("c3_instr", 32'(bus.instr), 32'h000000);
    chk("c3_len", 32'(bus.instr_len), 32'd1);
    chk("c3_pc", 32'(bus.instr_pc), 32'h0002);

    // Cold start with a 3-byte opcode.
    next_cycle();
    reset = 1'b1;
    img[0] = 8'hC3; img[1] = 8'h34; img[2] = 8'h12;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    model_restart(16'h0000);
    @(posedge clk); @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("jmp_c2_v", 32'(bus.instr_v), 32'd0);
    @(negedge clk);
    chk("jmp_c3_v", 32'(bus.instr_v), 32'd1);
    chk("jmp_c3_instr", 32'(bus.instr), 32'hC33412);
    chk("jmp_c3_len", 32'(bus.instr_len), 32'd3);

    // Undocumented alias CB at 0010.
    next_cycle();
    for (int i = 0; i < 5; i++) img[16'h0010 + i] = 8'h00;
    img[16'h0010] = 8'hCB;
    redirect_pulse(16'h0010);
    @(negedge clk);
    wait_v("cb_timeout");
    chk("cb_len", 32'(bus.instr_len), 32'(CB_LEN));
    chk("cb_pc", 32'(bus.instr_pc), 32'h0010);
    @(negedge clk);
    wait_v("cb_next_timeout");
    chk("cb_next_pc", 32'(bus.instr_pc), 32'(16'h0010 + 16'(CB_LEN)));

    // Decode stalls on a run of 00 bytes; the queue fills and fetch stops.
    next_cycle();
    for (int i = 0; i < 64; i++) img[16'h2000 + i] = 8'h00;
    bus.instr_ready = 1'b0;
    redirect_pulse(16'h2000);
    repeat (12) next_cycle();
    @(negedge clk);
    chk("stall_req", 32'(bus.fetch_req), 32'd0);
    chk("stall_v", 32'(bus.instr_v), 32'd1);
    next_cycle();
    bus.instr_ready = 1'b1;
    repeat (10) next_cycle();

    // Odd redirect while a response is still in flight.
    img[16'h0105] = 8'h3A; img[16'h0106] = 8'h00; img[16'h0107] = 8'h20;
    redirect_pulse(16'h2000);
    redirect_pulse(16'h0105);
    @(negedge clk);
    chk("odd_req", 32'(bus.fetch_req), 32'd1);
    chk("odd_addr", 32'(bus.fetch_addr), 32'h0104);
    wait_v("odd_timeout");
    chk("odd_instr", 32'(bus.instr), 32'h3A0020);
    chk("odd_pc", 32'(bus.instr_pc), 32'h0105);

    // Redirect to FFFF: operands wrap to 0000/0001.
    next_cycle();
    img[16'hFFFF] = 8'hC3; img[0] = 8'h00; img[1] = 8'h80;
    redirect_pulse(16'hFFFF);
    @(negedge clk);
    chk("wrap_req1", 32'(bus.fetch_req), 32'd1);
    chk("wrap_addr1", 32'(bus.fetch_addr), 32'hFFFE);
    @(negedge clk);
    chk("wrap_req2", 32'(bus.fetch_req), 32'd1);
    chk("wrap_addr2", 32'(bus.fetch_addr), 32'h0000);
    @(negedge clk);
    chk("wrap_req3", 32'(bus.fetch_req), 32'd1);
    chk("wrap_addr3", 32'(bus.fetch_addr), 32'h0002);
    wait_v("wrap_timeout");
    chk("wrap_instr", 32'(bus.instr), 32'hC30080);
    chk("wrap_pc", 32'(bus.instr_pc), 32'hFFFF);

    // Random stream with back-pressure and redirects, then a one-cycle reset.
    run_random(1500);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    model_restart(16'h0000);
    @(negedge clk);
    chk("rst_pulse_req", 32'(bus.fetch_req), 32'd0);
    chk("rst_pulse_pc", 32'(bus.instr_pc), 32'h0000);
    @(negedge clk);
    chk("rst_c0_req", 32'(bus.fetch_req), 32'd1);
    run_random(1500);
    bus.instr_ready = 1'b1;
    repeat (10) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
